// File: rtl/cpu_pkg.sv
// Shared definitions for the core's interrupt scheduler: bus map, state
// encoding and source limits.
package cpu_pkg;
    localparam int          MAX_SRC    = 8;
    localparam int          ID_W       = 3;
    localparam logic [31:0] IRQ_BASE   = 32'h4000_0020;
    localparam logic [31:0] OFF_IMASK  = 32'h0;
    localparam logic [31:0] OFF_IPEND  = 32'h4;
    localparam logic [31:0] OFF_ICAUSE = 32'h8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
module irq_prio_enc
    import cpu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    i_eligible,
    output logic            o_found,
    output logic [ID_W-1:0] o_id
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_found = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge-latched requests, mask/pending/cause registers,
// single-cycle IRQ pulse to the decoder and handler tracking until return.
module irq_sched
    import cpu_pkg::*;
#(
    parameter int          N_SRC       = 4,
    parameter int          ACK_TIMEOUT = 8,
    parameter logic [31:0] BASE        = IRQ_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_req,
    input  logic             kernel_mode,
    input  logic             pipe_ready,
    input  logic             bus_wr,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             irq,
    output logic             irq_busy
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    irq_state_e       r_state;
    irq_state_e       w_next;
    logic [N_SRC-1:0] r_src_prev;
    logic [N_SRC-1:0] r_imask;
    logic [N_SRC-1:0] r_ipend;
    logic [ID_W-1:0]  r_cause_id;
    logic             r_cause_valid;
    logic [7:0]       r_cnt;
    logic             r_seen_k;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_cause_oh;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_clr;
    logic             w_found;
    logic [ID_W-1:0]  w_win_id;
    logic             w_wr_mask;
    logic             w_wr_pend;
    logic             w_take;
    logic             w_ret;
    logic             w_timeout;
    logic             w_unused;

    assign w_rise     = src_req & ~r_src_prev;
    assign w_eligible = r_ipend & r_imask;
    assign w_wr_mask  = bus_wr && (bus_addr == BASE + OFF_IMASK);
    assign w_wr_pend  = bus_wr && (bus_addr == BASE + OFF_IPEND);
    assign w_unused   = ^bus_wdata[31:N_SRC];

    irq_prio_enc #(.N(N_SRC)) u_prio_enc (
        .i_eligible (w_eligible),
        .o_found    (w_found),
        .o_id       (w_win_id)
    );

    // Handshake: irq is a one-cycle pulse with no back-pressure. It is only
    // offered in a cycle where pipe_ready=1 and kernel_mode=0; the decoder is
    // then obliged to take it, and acceptance is observed as kernel_mode rising.
    assign w_take    = (r_state == IDLE) && w_found && !kernel_mode && pipe_ready;
    assign w_ret     = (r_state == SERVICE) && r_seen_k && !kernel_mode;
    assign w_timeout = (r_state == SERVICE) && !r_seen_k && (r_cnt == CNT_LAST);

    always_comb begin
        w_cause_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_cause_oh[i] = (r_cause_id == ID_W'(i));
        end
    end

    // Sets (new edges, flushed-IRQ re-pend) are ORed in last so they beat W1C.
    assign w_clr = (w_wr_pend ? bus_wdata[N_SRC-1:0] : '0)
                 | ((r_state == ISSUE) ? w_cause_oh : '0);
    assign w_set = w_rise | (w_timeout ? w_cause_oh : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = ISSUE;
            ISSUE:   w_next = SERVICE;
            SERVICE: if (w_ret || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        irq      = (r_state == ISSUE);
        irq_busy = (r_state == ISSUE) || (r_state == SERVICE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_prev    <= '0;
            r_imask       <= '0;
            r_ipend       <= '0;
            r_cause_id    <= '0;
            r_cause_valid <= 1'b0;
            r_cnt         <= '0;
            r_seen_k      <= 1'b0;
        end else begin
            r_src_prev <= src_req;
            r_ipend    <= (r_ipend & ~w_clr) | w_set;
            if (w_wr_mask) begin
                r_imask <= bus_wdata[N_SRC-1:0];
            end
            if (w_take) begin
                r_cause_id    <= w_win_id;
                r_cause_valid <= 1'b1;
            end else if (w_ret || w_timeout) begin
                r_cause_valid <= 1'b0;
            end
            if (r_state == ISSUE) begin
                r_cnt    <= '0;
                r_seen_k <= 1'b0;
            end else if (r_state == SERVICE) begin
                if (kernel_mode) r_seen_k <= 1'b1;
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_addr == BASE + OFF_IMASK) begin
            bus_rdata[N_SRC-1:0] = r_imask;
        end else if (bus_addr == BASE + OFF_IPEND) begin
            bus_rdata[N_SRC-1:0] = r_ipend;
        end else if (bus_addr == BASE + OFF_ICAUSE) begin
            bus_rdata = {r_cause_valid, 23'b0, 8'(r_cause_id)};
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: driver issues vectors and queues the expected
// IRQ cycle/cause and register reads; one monitor process compares them.
module tb_irq_sched;

    localparam logic [31:0] A_MASK  = 32'h4000_0020;
    localparam logic [31:0] A_PEND  = 32'h4000_0024;
    localparam logic [31:0] A_CAUSE = 32'h4000_0028;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_req;
    logic        kernel_mode;
    logic        pipe_ready;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic        irq_busy;

    int cyc = 0;

    logic [47:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] want_q[$];
    string       name_q[$];
    bit          done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    irq_sched dut (
        .clk         (clk),
        .reset       (reset),
        .src_req     (src_req),
        .kernel_mode (kernel_mode),
        .pipe_ready  (pipe_ready),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .irq         (irq),
        .irq_busy    (irq_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_wr    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_wr    = 1'b0;
        bus_addr  = A_CAUSE;
        bus_wdata = '0;
    endtask

    task automatic expect_read(input string nm, input logic [31:0] a, input logic [31:0] want);
        bus_addr = a;
        @(negedge clk);
        got_q.push_back(bus_rdata);
        want_q.push_back(want);
        name_q.push_back(nm);
        bus_addr = A_CAUSE;
    endtask

    task automatic expect_busy(input string nm, input logic want);
        @(negedge clk);
        got_q.push_back({31'b0, irq_busy});
        want_q.push_back({31'b0, want});
        name_q.push_back(nm);
    endtask

    task automatic expect_irq_low(input string nm);
        @(negedge clk);
        got_q.push_back({31'b0, irq});
        want_q.push_back(32'b0);
        name_q.push_back(nm);
    endtask

    task automatic push_exp(input int at, input logic [31:0] cause);
        exp_q.push_back({at[15:0], cause});
    endtask

    task automatic edge_src(input logic [3:0] bits);
        src_req = bits;
        step();
        src_req = '0;
    endtask

    // Kernel mode for two cycles then back to user; returns in the cycle
    // where kernel_mode has just dropped.
    task automatic handler();
        kernel_mode = 1'b1;
        step();
        step();
        kernel_mode = 1'b0;
    endtask

    // Driver
    initial begin
        int c;
        reset       = 1'b0;
        src_req     = '0;
        kernel_mode = 1'b0;
        pipe_ready  = 1'b1;
        bus_wr      = 1'b0;
        bus_addr    = A_CAUSE;
        bus_wdata   = '0;
        step();
        step();
        reset = 1'b1;
        step();
        expect_read("rst_imask", A_MASK, 32'h0);
        step();
        expect_read("rst_ipend", A_PEND, 32'h0);
        step();
        expect_read("rst_icause", A_CAUSE, 32'h0);
        step();
        expect_irq_low("rst_irq");
        expect_busy("rst_busy", 1'b0);
        step();

        // Single masked-in source
        bus_write(A_MASK, 32'h5);
        step();
        c = cyc;
        push_exp(c + 2, 32'h8000_0002);
        edge_src(4'b0100);
        step();
        step();
        expect_read("t1_ipend_cleared", A_PEND, 32'h0);
        step();
        expect_busy("t1_busy_service", 1'b1);
        step();
        handler();
        step();
        step();
        expect_read("t1_icause_after_ret", A_CAUSE, 32'h0000_0002);
        step();
        expect_busy("t1_busy_idle", 1'b0);
        step();

        // Two simultaneous sources: lowest first, the other after return
        bus_write(A_MASK, 32'hF);
        step();
        c = cyc;
        push_exp(c + 2, 32'h8000_0001);
        edge_src(4'b1010);
        step();
        step();
        expect_read("t2_ipend_src3", A_PEND, 32'h8);
        step();
        handler();
        c = cyc;
        push_exp(c + 2, 32'h8000_0003);
        step();
        step();
        step();
        expect_read("t2_ipend_empty", A_PEND, 32'h0);
        step();
        handler();
        step();
        step();
        step();

        // Masked edge pends, later mask write releases it
        bus_write(A_MASK, 32'h0);
        step();
        edge_src(4'b0001);
        step();
        step();
        expect_read("t3_ipend_masked", A_PEND, 32'h1);
        step();
        c = cyc;
        push_exp(c + 2, 32'h8000_0000);
        bus_write(A_MASK, 32'h1);
        step();
        step();
        step();
        handler();
        step();
        step();
        step();

        // No kernel entry: timeout re-pends and re-issues
        c = cyc;
        push_exp(c + 2, 32'h8000_0000);
        push_exp(c + 12, 32'h8000_0000);
        edge_src(4'b0001);
        repeat (9) step();
        expect_busy("t4_busy_waiting", 1'b1);
        step();
        expect_read("t4_ipend_repended", A_PEND, 32'h1);
        step();
        step();
        step();
        handler();
        step();
        step();
        step();

        // Set beats W1C; W1C alone clears
        bus_write(A_MASK, 32'h0);
        step();
        edge_src(4'b0001);
        step();
        expect_read("t5_ipend_pre", A_PEND, 32'h1);
        step();
        src_req = 4'b0001;
        bus_write(A_PEND, 32'h1);
        src_req = '0;
        expect_read("t5_set_wins", A_PEND, 32'h1);
        step();
        edge_src(4'b0010);
        step();
        bus_write(A_PEND, 32'h2);
        expect_read("t5_w1c", A_PEND, 32'h1);
        step();

        // pipe_ready low withholds the IRQ
        pipe_ready = 1'b0;
        bus_write(A_MASK, 32'h1);
        repeat (4) step();
        expect_busy("t5_withheld", 1'b0);
        step();
        pipe_ready = 1'b1;
        c = cyc;
        push_exp(c + 1, 32'h8000_0000);
        step();
        step();
        handler();
        step();
        step();
        step();

        // Reset during SERVICE, request line held high through it
        c = cyc;
        push_exp(c + 2, 32'h8000_0000);
        edge_src(4'b0001);
        step();
        step();
        step();
        src_req = 4'b0001;
        reset   = 1'b0;
        expect_irq_low("t6_irq_reset");
        expect_busy("t6_busy_reset", 1'b0);
        expect_read("t6_imask_reset", A_MASK, 32'h0);
        expect_read("t6_ipend_reset", A_PEND, 32'h0);
        expect_read("t6_icause_reset", A_CAUSE, 32'h0);
        step();
        reset = 1'b1;
        step();
        expect_read("t6_ipend_after_release", A_PEND, 32'h1);
        step();
        src_req = '0;
        expect_busy("t6_busy_after_release", 1'b0);
        step();
        step();
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_irq;
        logic [47:0] e;
        logic [31:0] g;
        logic [31:0] w;
        string       n;
        prev_irq = 1'b0;
        while (!done) begin
            @(negedge clk);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                w = want_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (g !== w) begin
                    errors++;
                    $display("FAIL %s got %08h want %08h", n, g, w);
                end
            end
            if (irq) begin
                checks++;
                if (prev_irq) begin
                    errors++;
                    $display("FAIL irq_double at cycle %0d got 1 want 0", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL irq_unexpected at cycle %0d cause %08h want no irq", cyc, bus_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e[47:32] !== cyc[15:0] || bus_rdata !== e[31:0]) begin
                        errors++;
                        $display("FAIL irq_issue got cycle %0d cause %08h want cycle %0d cause %08h",
                                 cyc, bus_rdata, e[47:32], e[31:0]);
                    end
                end
            end
            prev_irq = irq;
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            w = want_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL %s got %08h want %08h", n, g, w);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL irq_missing got %0d outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "bench stopped by watchdog");
    end

endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt scheduler for the pipelined MIPS core. Latches edge-triggered interrupt requests from peripherals, masks and prioritises them, and issues a single-cycle IRQ pulse to the instruction decoder only when the pipeline is in user mode and able to take it. It then tracks the handler until return and exposes mask/pending/cause registers on the peripheral bus.

## Interface
- N_SRC, 4: number of interrupt sources (1..8).
- ACK_TIMEOUT, 8: cycles allowed after IRQ for kernel_mode to rise before the request is re-pended.
- BASE, 32'h40000020: byte address of IMASK; IPEND = BASE+4, ICAUSE = BASE+8.

Ports:
- clk  in  1  core clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- src_req  in  N_SRC  peripheral request lines; a rising edge raises a request.
- kernel_mode  in  1  PC[31] of the ID-stage instruction.
- pipe_ready  in  1  ID stage may be replaced by the interrupt (no stall, no branch/jump in flight).
- bus_wr  in  1  write strobe.
- bus_addr  in  32  byte address.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational from bus_addr; 0 when the address is not decoded.
- irq  out  1  one-cycle pulse to the decoder's IRQ input.
- irq_busy  out  1  high in ISSUE and SERVICE.

## Operation
- Edge detect: src_prev register; rise = src_req & ~src_prev. src_prev resets to 0, so a line held high through reset raises a request on the first cycle after reset.
- IPEND[i] is set by rise[i]. It is cleared by a bus write of 1 to IPEND bit i (W1C) or by ISSUE of source i. If a set and a clear hit the same bit in the same cycle, set wins.
- IMASK is read/write over bits [N_SRC-1:0] and reads as 0 above that. Reset value is 0, so all sources start masked.
- ICAUSE is read-only: {valid, 23'b0, 8'(id)}. valid is set at ISSUE and cleared on return to IDLE from SERVICE.
- eligible = IPEND & IMASK. The winner is the lowest set index.
- FSM states: IDLE, ISSUE, SERVICE.
  - IDLE -> ISSUE when eligible != 0 && !kernel_mode && pipe_ready. The winner id is latched into cause_id.
  - ISSUE, one cycle: irq=1 and IPEND[cause_id] is cleared. Go to SERVICE and zero the timeout counter and the seen_k flag.
  - SERVICE: seen_k is set on the first cycle kernel_mode=1.
  - SERVICE exits to IDLE when seen_k && !kernel_mode (handler returned). ICAUSE.valid is cleared.
  - SERVICE also exits to IDLE when !seen_k and the counter reaches ACK_TIMEOUT-1 (the IRQ was flushed). IPEND[cause_id] is set again; this set wins over a same-cycle W1C.
- No nesting: new edges during ISSUE or SERVICE only set IPEND.
- IMASK and bus writes take effect the following cycle. Clearing a mask bit during SERVICE does not abort the service.

## Timing
- Reset values: irq=0, irq_busy=0, IMASK=0, IPEND=0, ICAUSE=0, state=IDLE, counter=0, src_prev=0.
- Latency with mask set, user mode and pipe_ready=1:
  - edge sampled at cycle t
  - IPEND bit visible at t+1
  - ISSUE at t+2, with irq high for that cycle only
  - SERVICE from t+3
- irq never stays high for two consecutive cycles.
- Minimum IDLE dwell after SERVICE is one cycle.
- Reset in mid-operation returns to the reset values immediately. Any in-flight IRQ is lost and is not re-pended.
- The counter is 8 bits wide and saturates. ACK_TIMEOUT must be ≤ 255.

## Structure
- Shared package (cpu_pkg): IRQ_BASE address, register offsets, the state enum {IDLE, ISSUE, SERVICE}, and MAX_SRC=8.
- One sub-module, irq_prio_enc: a combinational lowest-index priority encoder giving {found, id} from eligible.
- Bus decode, W1C logic, FSM and counter live in irq_sched.

## Test plan
- IMASK=4'b0101, edge on src_req[2] with kernel_mode=0 and pipe_ready=1 -> irq pulse at t+2, ICAUSE=32'h80000002, IPEND[2]=0.
- Edges on sources 3 and 1 in the same cycle, both unmasked -> source 1 issued first. Source 3 is issued after kernel_mode goes 1 then 0, with ICAUSE then reading 32'h80000003.
- Edge while IMASK=0 -> no irq and IPEND=1. A later IMASK write enables it -> irq two cycles after the write.
- irq issued but kernel_mode held 0 for 8 cycles -> return to IDLE with IPEND bit set again. irq re-issues on the next eligible cycle.
- W1C of IPEND[0] in the same cycle as a new edge on src_req[0] -> IPEND[0] stays 1. pipe_ready=0 held for 5 cycles -> irq is withheld until pipe_ready=1.
- Assert reset during SERVICE -> next cycle all registers are 0, irq=0, irq_busy=0, and src_req[0] high -> IPEND[0]=1 after release.
